// File: rtl/byte_alu_pkg.sv
// rtl/byte_alu_pkg.sv - shared types and constants for the byte-serial ALU path
package byte_alu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 used for sizing the byte index; returns at least 1.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/RCA_8.sv
// rtl/RCA_8.sv - 8-bit ripple-carry adder slice
module RCA_8
    import byte_alu_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    input  logic [BYTE_W-1:0] B,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    // Full-adder chain, bit 0 first; carry is local to this block.
    always_comb begin
        logic [BYTE_W:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        cout = c[BYTE_W];
    end

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// rtl/byte_serial_adder_ctrl.sv - wide add/sub sequenced through one 8-bit adder, LSB first
module byte_serial_adder_ctrl
    import byte_alu_pkg::*;
#(
    parameter int NBYTES = 4,
    localparam int W     = BYTE_W * NBYTES,
    localparam int IW    = clog2(NBYTES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         busy
);

    state_t state;
    state_t state_nxt;

    logic [NBYTES-1:0][BYTE_W-1:0] a_reg;
    logic [NBYTES-1:0][BYTE_W-1:0] b_reg;
    logic [NBYTES-1:0][BYTE_W-1:0] res_reg;
    logic [IW-1:0]                 idx;
    logic                          carry_reg;

    logic              load;
    logic              step;
    logic              last;
    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;

    assign last = (idx == IW'(NBYTES - 1));

    // Single shared adder; the carry between bytes only travels through carry_reg.
    RCA_8 u_rca (
        .A    (a_reg[idx]),
        .B    (b_reg[idx]),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-byte result write and carry/index update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
        end else if (load) begin
            a_reg     <= A;
            b_reg     <= sub ? ~B : B;
            carry_reg <= sub ? 1'b1 : cin;
            idx       <= '0;
        end else if (step) begin
            res_reg[idx] <= add_sum;
            carry_reg    <= add_cout;
            idx          <= last ? '0 : idx + IW'(1);
        end
    end

    // Overflow uses the stored (possibly inverted) B so subtract needs no special case.
    assign sum      = res_reg;
    assign cout     = carry_reg;
    assign overflow = (a_reg[NBYTES-1][BYTE_W-1] == b_reg[NBYTES-1][BYTE_W-1]) &&
                      (res_reg[NBYTES-1][BYTE_W-1] != a_reg[NBYTES-1][BYTE_W-1]);

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// tb/tb_byte_serial_adder_ctrl.sv - directed self-checking bench for byte_serial_adder_ctrl
module tb_byte_serial_adder_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    int tests;
    int fails;

    byte_serial_adder_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, confirm acceptance, then wait (bounded) for out_valid.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, input logic hold_valid);
        A        = a;
        B        = b;
        sub      = s;
        cin      = c;
        in_valid = 1'b1;
        check("accept_in_ready", 64'(in_ready), 64'd1);
        tick();
        if (!hold_valid) in_valid = 1'b0;
        check("run_busy", 64'(busy), 64'd1);
        check("run_in_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] exp_sum,
                             input logic exp_cout, input logic exp_ov);
        int lat;
        wait_result(lat);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ov));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_sum;
        logic         held_cout;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #5;

        issue(32'h0000_00F0, 32'h0000_0078, 1'b0, 1'b0, 1'b0);
        finish_op("add", 32'h0000_0168, 1'b0, 1'b0);

        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        finish_op("ripple", 32'h0000_0000, 1'b1, 1'b0);

        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        finish_op("sovf", 32'h8000_0000, 1'b0, 1'b1);

        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
        finish_op("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);

        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        finish_op("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure with in_valid held high the whole time.
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        A = 32'h0000_0010;
        B = 32'h0000_0020;
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'd4);
        held_sum  = 32'h0000_0003;
        held_cout = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(sum), 64'(held_sum));
            check("bp_cout", 64'(cout), 64'(held_cout));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_accept_drop", 64'(out_valid), 64'd0);
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_busy", 64'(busy), 64'd0);
        tick();
        in_valid = 1'b0;
        check("bp_next_busy", 64'(busy), 64'd1);
        finish_op("bp_next", 32'h0000_0030, 1'b0, 1'b0);

        // Reset in the middle of RUN aborts without an out_valid pulse.
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        finish_op("post_rst", 32'h0000_0002, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
